ei_axi4_wr_txn_collector: RTL and testbench
===========================================

Name: ei_axi4_wr_txn_collector

Overview:
- Passive, synthesizable write-path stage that consumes the same AXI4 AW/W/B bus signals the monitor interface samples.
- Pairs each write address with its data burst and its write response.
- Emits one registered transaction record per completed write, plus sticky protocol-error flags.
- Sits directly downstream of the monitor tap. It feeds scoreboards/coverage or on-chip trace. It never drives the bus.

Parameters:
- DATA_WIDTH, 32, write data bus width (multiple of 8); BYTE_LANES = DATA_WIDTH/8
- ADDR_WIDTH, 32, address width
- AW_DEPTH, 4, address FIFO entries (power of 2, ≥2)
- WD_DEPTH, 4, completed-data-burst FIFO entries (power of 2, ≥2)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- awaddr  in  ADDR_WIDTH  write address
- awlen  in  8  burst length-1
- awsize  in  3  beat size
- awburst  in  2  burst type
- awvalid/awready  in  1 each  AW handshake
- wstrb  in  BYTE_LANES  write strobes
- wlast/wvalid/wready  in  1 each  W channel
- bresp  in  2  write response
- bvalid/bready  in  1 each  B handshake
- err_clear  in  1  clears sticky error flags
- txn_valid  out  1  one-cycle pulse, record valid
- txn_addr  out  ADDR_WIDTH; txn_len out 8; txn_size out 3; txn_burst out 2  from AW
- txn_beats  out  9  W beats observed
- txn_bytes  out  clog2(256*BYTE_LANES)+1  sum of set wstrb bits
- txn_resp  out  2  bresp
- txn_len_err  out  1  txn_beats != txn_len+1
- err_b_early, err_aw_ovf, err_w_ovf  out  1 each  sticky errors

Behaviour:
- Handshakes are sampled on the posedge of aclk: AW = awvalid&&awready; W = wvalid&&wready; B = bvalid&&bready.
- Reset: synchronous. Clears both FIFOs, the beat/byte accumulators, and all outputs to 0. A partial burst in progress at reset is discarded. Reset overrides err_clear.
- AW handshake: push {awaddr,awlen,awsize,awburst} into the AW FIFO.
- AW FIFO full with no same-cycle pop: drop the entry and set err_aw_ovf.
- W handshake: beat_cnt += 1, saturating at 511; byte_acc += popcount(wstrb).
- W handshake with wlast=1: push {beat_cnt+1, byte_acc+popcount} into the WD FIFO, then zero both accumulators.
- WD FIFO full with no same-cycle pop: drop the entry and set err_w_ovf. The accumulators are still cleared.
- Data may precede its address. Pairing is strictly in order: AW head with WD head.
- B handshake with both FIFOs non-empty, using occupancy before this edge:
  - pop both heads;
  - next cycle: txn_valid=1, txn_* loaded from the heads, txn_resp=bresp, txn_len_err computed.
  - Latency is exactly 1 cycle from the B handshake edge.
- B handshake with either FIFO empty: set err_b_early, no pop, no txn_valid.
- Same-edge push and pop:
  - A push arriving on the same edge as a B is not visible to that B.
  - Pop and push on the same edge to a full FIFO both succeed; occupancy is unchanged and no overflow is flagged.
- txn_valid deasserts after 1 cycle. txn_* fields hold their last values until the next record.
- Sticky errors: stay set until err_clear=1 or areset. If err_clear and a new error occur on the same edge, the error wins (flag reads 1).
- No backpressure. The block never stalls and never affects ready signals.

Test Plan:
- AW addr 0x100, len 3, size 2, INCR; 4 W beats wstrb 0xF, wlast on beat 4; B OKAY -> txn_valid 1 cycle after B: addr 0x100, len 3, beats 4, bytes 16, resp 0, len_err 0.
- Data first: W beats wstrb 0x3, then 0x1 with wlast; then AW len 1; B SLVERR -> beats 2, bytes 3, resp 2, len_err 0.
- AW len 3, wlast on beat 2, B OKAY -> beats 2, len_err 1; a following correct burst -> len_err 0.
- B with no prior AW/W -> err_b_early=1, no txn_valid; pulse err_clear -> err_b_early=0 next cycle.
- 5 AW handshakes with no pop (AW_DEPTH 4) -> err_aw_ovf=1. Then 4 bursts + 4 B -> exactly 4 records with the first 4 addresses; the 5th address is absent.
- 2 W beats (no wlast), areset 1 cycle; then AW len 0, 1 beat wstrb 0x1 with wlast, B -> beats 1, bytes 1, len_err 0, all errors 0.

Source files
------------

// File: rtl/ei_axi4_wr_txn_collector.sv
// Passive AXI4 write-path collector: pairs each AW with its completed W burst
// and its B response, in order, and emits one registered record per write.

module ei_axi4_wr_txn_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty  = (count == '0);
   assign full   = (count == FULL_CNT);
   assign do_pop = pop && !empty;
   // A pop on the same edge frees a slot, so a full FIFO still takes the push.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

module ei_axi4_wr_txn_collector #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int AW_DEPTH   = 4,
   parameter int WD_DEPTH   = 4
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [ADDR_WIDTH-1:0]             awaddr,
   input  logic [7:0]                        awlen,
   input  logic [2:0]                        awsize,
   input  logic [1:0]                        awburst,
   input  logic                              awvalid,
   input  logic                              awready,
   input  logic [DATA_WIDTH/8-1:0]           wstrb,
   input  logic                              wlast,
   input  logic                              wvalid,
   input  logic                              wready,
   input  logic [1:0]                        bresp,
   input  logic                              bvalid,
   input  logic                              bready,
   input  logic                              err_clear,
   output logic                              txn_valid,
   output logic [ADDR_WIDTH-1:0]             txn_addr,
   output logic [7:0]                        txn_len,
   output logic [2:0]                        txn_size,
   output logic [1:0]                        txn_burst,
   output logic [8:0]                        txn_beats,
   output logic [$clog2(32*DATA_WIDTH):0]    txn_bytes,
   output logic [1:0]                        txn_resp,
   output logic                              txn_len_err,
   output logic                              err_b_early,
   output logic                              err_aw_ovf,
   output logic                              err_w_ovf
);
   localparam int BYTE_LANES = DATA_WIDTH / 8;
   localparam int BYTES_W    = $clog2(32 * DATA_WIDTH) + 1;
   localparam int AW_W       = ADDR_WIDTH + 13;
   localparam int WD_W       = 9 + BYTES_W;

   // A transfer on any channel happens on a posedge where its valid and ready
   // are both high; this block only observes and never influences ready.
   logic aw_hs;
   logic w_hs;
   logic b_hs;
   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign b_hs  = bvalid && bready;

   logic [AW_W-1:0] aw_din;
   logic [AW_W-1:0] aw_head;
   logic            aw_empty;
   logic            aw_full;
   logic [WD_W-1:0] wd_din;
   logic [WD_W-1:0] wd_head;
   logic            wd_empty;
   logic            wd_full;
   logic            txn_pop;
   logic            wd_push;

   logic [8:0]         beat_cnt;
   logic [8:0]         beat_nxt;
   logic [BYTES_W-1:0] byte_acc;
   logic [BYTES_W-1:0] byte_nxt;
   logic [BYTES_W:0]   byte_sum;
   logic [BYTES_W-1:0] strb_cnt;

   always_comb begin
      strb_cnt = '0;
      for (int i = 0; i < BYTE_LANES; i++) begin
         strb_cnt = strb_cnt + BYTES_W'(wstrb[i]);
      end
   end

   assign beat_nxt = (beat_cnt == 9'd511) ? beat_cnt : beat_cnt + 9'd1;
   assign byte_sum = {1'b0, byte_acc} + {1'b0, strb_cnt};
   assign byte_nxt = byte_sum[BYTES_W] ? '1 : byte_sum[BYTES_W-1:0];

   // Pairing decision uses occupancy before this edge, so same-edge pushes
   // are invisible to the B that arrives with them.
   assign txn_pop = b_hs && !aw_empty && !wd_empty;
   assign wd_push = w_hs && wlast;
   assign aw_din  = {awaddr, awlen, awsize, awburst};
   assign wd_din  = {beat_nxt, byte_nxt};

   ei_axi4_wr_txn_fifo #(.W(AW_W), .DEPTH(AW_DEPTH)) u_aw_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (aw_hs),
      .pop    (txn_pop),
      .din    (aw_din),
      .dout   (aw_head),
      .empty  (aw_empty),
      .full   (aw_full)
   );

   ei_axi4_wr_txn_fifo #(.W(WD_W), .DEPTH(WD_DEPTH)) u_wd_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (wd_push),
      .pop    (txn_pop),
      .din    (wd_din),
      .dout   (wd_head),
      .empty  (wd_empty),
      .full   (wd_full)
   );

   always_ff @(posedge aclk) begin
      if (areset || wd_push) begin
         beat_cnt <= '0;
         byte_acc <= '0;
      end else if (w_hs) begin
         beat_cnt <= beat_nxt;
         byte_acc <= byte_nxt;
      end
   end

   logic b_early_evt;
   logic aw_ovf_evt;
   logic w_ovf_evt;
   assign b_early_evt = b_hs && (aw_empty || wd_empty);
   assign aw_ovf_evt  = aw_hs && aw_full && !txn_pop;
   assign w_ovf_evt   = wd_push && wd_full && !txn_pop;

   always_ff @(posedge aclk) begin
      if (areset) begin
         txn_valid   <= 1'b0;
         txn_addr    <= '0;
         txn_len     <= '0;
         txn_size    <= '0;
         txn_burst   <= '0;
         txn_beats   <= '0;
         txn_bytes   <= '0;
         txn_resp    <= '0;
         txn_len_err <= 1'b0;
         err_b_early <= 1'b0;
         err_aw_ovf  <= 1'b0;
         err_w_ovf   <= 1'b0;
      end else begin
         txn_valid <= txn_pop;
         if (txn_pop) begin
            txn_addr    <= aw_head[AW_W-1 -: ADDR_WIDTH];
            txn_len     <= aw_head[12:5];
            txn_size    <= aw_head[4:2];
            txn_burst   <= aw_head[1:0];
            txn_beats   <= wd_head[WD_W-1 -: 9];
            txn_bytes   <= wd_head[BYTES_W-1:0];
            txn_resp    <= bresp;
            txn_len_err <= (wd_head[WD_W-1 -: 9] != ({1'b0, aw_head[12:5]} + 9'd1));
         end
         // A new error on the clearing edge wins.
         err_b_early <= (err_b_early && !err_clear) || b_early_evt;
         err_aw_ovf  <= (err_aw_ovf && !err_clear) || aw_ovf_evt;
         err_w_ovf   <= (err_w_ovf && !err_clear) || w_ovf_evt;
      end
   end
endmodule

// File: tb/tb_ei_axi4_wr_txn_collector.sv
// Scoreboard bench for ei_axi4_wr_txn_collector: a queue-based reference model
// predicts records and sticky errors; a monitor checks every cycle.

module tb_ei_axi4_wr_txn_collector;
   localparam int REC_W = 32 + 8 + 3 + 2 + 9 + 11 + 2 + 1;
   localparam int DEPTH = 4;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid, awready;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic        err_clear;
   logic        txn_valid;
   logic [31:0] txn_addr;
   logic [7:0]  txn_len;
   logic [2:0]  txn_size;
   logic [1:0]  txn_burst;
   logic [8:0]  txn_beats;
   logic [10:0] txn_bytes;
   logic [1:0]  txn_resp;
   logic        txn_len_err;
   logic        err_b_early, err_aw_ovf, err_w_ovf;

   ei_axi4_wr_txn_collector dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .err_clear(err_clear),
      .txn_valid(txn_valid), .txn_addr(txn_addr), .txn_len(txn_len),
      .txn_size(txn_size), .txn_burst(txn_burst), .txn_beats(txn_beats),
      .txn_bytes(txn_bytes), .txn_resp(txn_resp), .txn_len_err(txn_len_err),
      .err_b_early(err_b_early), .err_aw_ovf(err_aw_ovf), .err_w_ovf(err_w_ovf)
   );

   // ---------------- clock / reset ----------------
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   logic [REC_W-1:0] exp_q[$];
   int               exp_cyc_q[$];
   logic [REC_W-1:0] last_rec = '0;

   // reference model: address queue {addr,len,size,burst}, data queue {beats,bytes}
   logic [44:0] m_aw_q[$];
   logic [19:0] m_wd_q[$];
   int          m_beats = 0;
   int          m_bytes = 0;
   logic        m_b_early = 1'b0, m_aw_ovf = 1'b0, m_w_ovf = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic model_step();
      bit aw_hs, w_hs, b_hs;
      logic [44:0] a;
      logic [19:0] d;
      logic        len_err;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      if (areset) begin
         m_aw_q.delete();
         m_wd_q.delete();
         exp_q.delete();
         exp_cyc_q.delete();
         m_beats = 0;
         m_bytes = 0;
         m_b_early = 1'b0;
         m_aw_ovf = 1'b0;
         m_w_ovf = 1'b0;
         last_rec = '0;
         return;
      end
      if (err_clear) begin
         m_b_early = 1'b0;
         m_aw_ovf = 1'b0;
         m_w_ovf = 1'b0;
      end
      if (b_hs) begin
         if (m_aw_q.size() > 0 && m_wd_q.size() > 0) begin
            a = m_aw_q.pop_front();
            d = m_wd_q.pop_front();
            len_err = (int'(d[19:11]) != int'(a[12:5]) + 1);
            exp_q.push_back({a, d, bresp, len_err});
            exp_cyc_q.push_back(cyc + 1);
         end else begin
            m_b_early = 1'b1;
         end
      end
      if (aw_hs) begin
         if (m_aw_q.size() < DEPTH) m_aw_q.push_back({awaddr, awlen, awsize, awburst});
         else m_aw_ovf = 1'b1;
      end
      if (w_hs) begin
         m_beats = (m_beats < 511) ? m_beats + 1 : 511;
         m_bytes = m_bytes + $countones(wstrb);
         if (wlast) begin
            if (m_wd_q.size() < DEPTH) m_wd_q.push_back({9'(m_beats), 11'(m_bytes)});
            else m_w_ovf = 1'b1;
            m_beats = 0;
            m_bytes = 0;
         end
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge aclk) begin
      logic [REC_W-1:0] got;
      logic [REC_W-1:0] e;
      int               ec;
      #1;
      if (mon_en) begin
         got = {txn_addr, txn_len, txn_size, txn_burst, txn_beats, txn_bytes, txn_resp, txn_len_err};
         if (txn_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL txn_unexpected actual=%0h required=no record (cycle %0d)", got, cyc);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check("txn_record", got, e);
               check("txn_latency", cyc, ec);
               last_rec = e;
            end
         end else begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
               checks++;
               failures++;
               $display("FAIL txn_missing actual=none required=%0h (cycle %0d)", exp_q[0], cyc);
               void'(exp_q.pop_front());
               void'(exp_cyc_q.pop_front());
            end
            check("txn_hold", got, last_rec);
         end
         check("err_flags", {err_b_early, err_aw_ovf, err_w_ovf}, {m_b_early, m_aw_ovf, m_w_ovf});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      areset = 1'b0; err_clear = 1'b0;
      awvalid = 1'b0; awready = 1'b0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      wvalid = 1'b0; wready = 1'b0; wstrb = '0; wlast = 1'b0;
      bvalid = 1'b0; bready = 1'b0; bresp = '0;
   endtask

   task automatic tick();
      model_step();
      @(posedge aclk);
      @(negedge aclk);
      clear_inputs();
   endtask

   task automatic set_aw(input logic [31:0] a, input logic [7:0] l);
      awaddr = a; awlen = l; awsize = 3'd2; awburst = 2'd1;
      awvalid = 1'b1; awready = 1'b1;
   endtask

   task automatic set_w(input logic [3:0] s, input logic last);
      wstrb = s; wlast = last; wvalid = 1'b1; wready = 1'b1;
   endtask

   task automatic set_b(input logic [1:0] r);
      bresp = r; bvalid = 1'b1; bready = 1'b1;
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [7:0] l);
      set_aw(a, l);
      tick();
   endtask

   task automatic send_w(input logic [3:0] s, input logic last);
      set_w(s, last);
      tick();
   endtask

   task automatic send_b(input logic [1:0] r);
      set_b(r);
      tick();
   endtask

   task automatic pulse_reset();
      areset = 1'b1;
      tick();
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      tick();
   endtask

   // Called right after a B cycle: the record is visible until the next edge.
   task automatic expect_rec(input string name, input logic [31:0] a, input logic [7:0] l,
                             input logic [8:0] beats, input logic [10:0] bytes,
                             input logic [1:0] r, input logic le);
      check({name, "_valid"}, txn_valid, 1'b1);
      check({name, "_addr"}, txn_addr, a);
      check({name, "_len"}, txn_len, l);
      check({name, "_beats"}, txn_beats, beats);
      check({name, "_bytes"}, txn_bytes, bytes);
      check({name, "_resp"}, txn_resp, r);
      check({name, "_len_err"}, txn_len_err, le);
   endtask

   task automatic expect_flags(input string name, input logic b, input logic a, input logic w);
      check(name, {err_b_early, err_aw_ovf, err_w_ovf}, {b, a, w});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_inputs();
      @(negedge aclk);
      pulse_reset();
      mon_en = 1'b1;
      check("reset_txn_valid", txn_valid, 1'b0);
      check("reset_txn_fields", {txn_addr, txn_len, txn_beats, txn_bytes, txn_resp, txn_len_err}, '0);
      expect_flags("reset_flags", 1'b0, 1'b0, 1'b0);

      // basic INCR burst
      send_aw(32'h100, 8'd3);
      for (int i = 0; i < 4; i++) send_w(4'hF, i == 3);
      send_b(2'd0);
      expect_rec("basic", 32'h100, 8'd3, 9'd4, 11'd16, 2'd0, 1'b0);
      tick();
      check("pulse_one_cycle", txn_valid, 1'b0);

      // data before address
      send_w(4'h3, 1'b0);
      send_w(4'h1, 1'b1);
      send_aw(32'h200, 8'd1);
      send_b(2'd2);
      expect_rec("data_first", 32'h200, 8'd1, 9'd2, 11'd3, 2'd2, 1'b0);

      // short burst then a correct one
      send_aw(32'h300, 8'd3);
      send_w(4'hF, 1'b0);
      send_w(4'hF, 1'b1);
      send_b(2'd0);
      expect_rec("short", 32'h300, 8'd3, 9'd2, 11'd8, 2'd0, 1'b1);
      send_aw(32'h340, 8'd1);
      send_w(4'hF, 1'b0);
      send_w(4'hF, 1'b1);
      send_b(2'd0);
      expect_rec("correct", 32'h340, 8'd1, 9'd2, 11'd8, 2'd0, 1'b0);

      // B with nothing to pair
      send_b(2'd0);
      check("early_no_valid", txn_valid, 1'b0);
      expect_flags("early_flag", 1'b1, 1'b0, 1'b0);
      pulse_clear();
      expect_flags("early_cleared", 1'b0, 1'b0, 1'b0);

      // address FIFO overflow: fifth address dropped
      for (int i = 0; i < 5; i++) send_aw(32'h1000 + 32'(i) * 32'h10, 8'd0);
      expect_flags("aw_ovf_flag", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_w(4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_b(2'd0);
         expect_rec("ovf_rec", 32'h1000 + 32'(i) * 32'h10, 8'd0, 9'd1, 11'd4, 2'd0, 1'b0);
      end
      send_b(2'd0);
      check("ovf_fifth_absent", txn_valid, 1'b0);

      // partial burst discarded by reset
      send_w(4'hF, 1'b0);
      send_w(4'hF, 1'b0);
      pulse_reset();
      expect_flags("reset_clears_flags", 1'b0, 1'b0, 1'b0);
      send_aw(32'h500, 8'd0);
      send_w(4'h1, 1'b1);
      send_b(2'd0);
      expect_rec("after_reset", 32'h500, 8'd0, 9'd1, 11'd1, 2'd0, 1'b0);
      expect_flags("after_reset_flags", 1'b0, 1'b0, 1'b0);

      // same-edge push and pop on a full address FIFO
      for (int i = 0; i < 4; i++) send_aw(32'h2000 + 32'(i) * 32'h10, 8'd0);
      send_w(4'hF, 1'b1);
      set_aw(32'h2040, 8'd0);
      set_w(4'h3, 1'b1);
      set_b(2'd1);
      tick();
      expect_rec("same_edge", 32'h2000, 8'd0, 9'd1, 11'd4, 2'd1, 1'b0);
      expect_flags("same_edge_no_ovf", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_w(4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_b(2'd0);
         expect_rec("drain", 32'h2010 + 32'(i) * 32'h10, 8'd0, 9'd1, (i == 0) ? 11'd2 : 11'd4, 2'd0, 1'b0);
      end

      // pushes arriving with a B are not visible to it
      set_aw(32'h3000, 8'd0);
      set_w(4'h1, 1'b1);
      set_b(2'd0);
      tick();
      check("invisible_push_no_valid", txn_valid, 1'b0);
      expect_flags("invisible_push_flag", 1'b1, 1'b0, 1'b0);
      send_b(2'd3);
      expect_rec("invisible_next", 32'h3000, 8'd0, 9'd1, 11'd1, 2'd3, 1'b0);
      // clear and a new error on the same edge: error wins
      err_clear = 1'b1;
      set_b(2'd0);
      tick();
      expect_flags("clear_vs_new", 1'b1, 1'b0, 1'b0);
      pulse_clear();

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         awaddr  = $urandom;
         awlen   = 8'($urandom_range(0, 3));
         awsize  = 3'($urandom_range(0, 2));
         awburst = 2'($urandom_range(0, 2));
         awvalid = ($urandom_range(0, 3) == 0);
         awready = ($urandom_range(0, 3) != 0);
         wstrb   = 4'($urandom);
         wlast   = ($urandom_range(0, 2) == 0);
         wvalid  = ($urandom_range(0, 1) == 0);
         wready  = ($urandom_range(0, 3) != 0);
         bresp   = 2'($urandom);
         bvalid  = ($urandom_range(0, 4) == 0);
         bready  = ($urandom_range(0, 3) != 0);
         err_clear = ($urandom_range(0, 29) == 0);
         tick();
      end

      for (int i = 0; i < 4; i++) tick();
      check("exp_q_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
